// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: command handshake, operand-buffer read port and array
// feed/enable lines of the systolic sequencing controller.
// The abort line exists only when SYSTOLIC_SEQ_ABORT_EN is defined.
interface systolic_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3,
  parameter int K_WIDTH    = 8
);
  logic                    start;
  logic [K_WIDTH-1:0]      k_len;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [K_WIDTH-1:0]      rd_addr;
  logic [DATA_WIDTH*N-1:0] a_rd_data;
  logic [DATA_WIDTH*N-1:0] b_rd_data;
  logic [DATA_WIDTH*N-1:0] a_feed;
  logic [DATA_WIDTH*N-1:0] b_feed;
  logic                    mac_clr;
  logic                    mac_en;
`ifdef SYSTOLIC_SEQ_ABORT_EN
  logic                    abort;

  // Controller side.
  modport slave (
    input  start, k_len, a_rd_data, b_rd_data, abort,
    output busy, done, rd_en, rd_addr, a_feed, b_feed, mac_clr, mac_en
  );
  // Host / operand buffer / array side.
  modport master (
    output start, k_len, a_rd_data, b_rd_data, abort,
    input  busy, done, rd_en, rd_addr, a_feed, b_feed, mac_clr, mac_en
  );
`else
  // Controller side.
  modport slave (
    input  start, k_len, a_rd_data, b_rd_data,
    output busy, done, rd_en, rd_addr, a_feed, b_feed, mac_clr, mac_en
  );
  // Host / operand buffer / array side.
  modport master (
    output start, k_len, a_rd_data, b_rd_data,
    input  busy, done, rd_en, rd_addr, a_feed, b_feed, mac_clr, mac_en
  );
`endif
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences one N x N systolic MAC job
// (clear -> fetch K slices -> diagonal skew -> drain -> done pulse).
// Optional feature: define SYSTOLIC_SEQ_ABORT_EN to add the abort input,
// which cancels a job in CLEAR/FEED/DRAIN without a done pulse.
module systolic_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3,
  parameter int K_WIDTH    = 8
) (
  input logic               clk,
  input logic               rst_n,
  systolic_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

  // Drain lasts 2N cycles: read latency, worst-case skew and the MAC itself.
  localparam int                DCNT_W    = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(2 * N - 1);

  state_e              state_q;
  logic [K_WIDTH-1:0]  k_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [K_WIDTH-1:0]  rd_addr_q;
  logic                mac_clr_q;
  logic                mac_en_q;
  logic                rd_vld_q;
  logic                abort_req;
  logic                abort_go;

`ifdef SYSTOLIC_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort only has an effect while a job is actually in flight.
  assign abort_go = abort_req &&
                    ((state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN));

  // Job FSM with registered outputs that already reflect the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
    end else if (abort_go) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A zero-length command would never produce data; drop it.
          if (bus.start && (bus.k_len != '0)) begin
            state_q   <= S_CLEAR;
            k_q       <= bus.k_len;
            busy_q    <= 1'b1;
            mac_clr_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q   <= S_FEED;
          mac_clr_q <= 1'b0;
          mac_en_q  <= 1'b1;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
        S_FEED: begin
          if (rd_addr_q == k_q - K_WIDTH'(1)) begin
            state_q   <= S_DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dcnt_q    <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + K_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DCNT_LAST) begin
            state_q  <= S_DONE;
            mac_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after rd_en; this marks it valid for lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
    end else if (abort_go) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_q;
    end
  end

  // Per-lane skew: lane gi is delayed gi cycles so the array sees a diagonal wavefront.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic [DATA_WIDTH-1:0] a_out;
    logic [DATA_WIDTH-1:0] b_out;

    assign a_in = bus.a_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign b_in = bus.b_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];

    if (gi == 0) begin : g_direct
      // Lane 0 has no delay; invalid cycles drive zero so accumulators add nothing.
      assign a_out = rd_vld_q ? a_in : '0;
      assign b_out = rd_vld_q ? b_in : '0;
    end else begin : g_skew
      logic                  vld_q [gi];
      logic [DATA_WIDTH-1:0] a_q   [gi];
      logic [DATA_WIDTH-1:0] b_q   [gi];

      // Shift valid and data through gi stages; abort flushes the chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < gi; s++) begin
            vld_q[s] <= 1'b0;
            a_q[s]   <= '0;
            b_q[s]   <= '0;
          end
        end else if (abort_go) begin
          for (int s = 0; s < gi; s++) begin
            vld_q[s] <= 1'b0;
            a_q[s]   <= '0;
            b_q[s]   <= '0;
          end
        end else begin
          vld_q[0] <= rd_vld_q;
          a_q[0]   <= a_in;
          b_q[0]   <= b_in;
          for (int s = 1; s < gi; s++) begin
            vld_q[s] <= vld_q[s-1];
            a_q[s]   <= a_q[s-1];
            b_q[s]   <= b_q[s-1];
          end
        end
      end

      assign a_out = vld_q[gi-1] ? a_q[gi-1] : '0;
      assign b_out = vld_q[gi-1] ? b_q[gi-1] : '0;
    end

    assign bus.a_feed[gi*DATA_WIDTH +: DATA_WIDTH] = a_out;
    assign bus.b_feed[gi*DATA_WIDTH +: DATA_WIDTH] = b_out;
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.mac_en  = mac_en_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: table-driven, directed and randomized jobs against a
// cycle-level expectation derived from the job timing rules, plus a
// behavioural model of the N x N array that must reproduce A*B.
module tb_systolic_seq_ctrl;
  localparam int DW   = 32;
  localparam int N    = 3;
  localparam int KW   = 8;
  localparam int MAXK = 16;
  localparam int VW   = DW * N;

  localparam int EV_NONE  = 0;
  localparam int EV_BUSY  = 1;
  localparam int EV_RST   = 2;
  localparam int EV_ABORT = 3;

  localparam int PAT_ID   = 0;
  localparam int PAT_SKEW = 1;
  localparam int PAT_RAND = 2;
  localparam int PAT_ONES = 3;

  typedef struct packed {
    int k;
    int pat;
    int exp_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) bus ();

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [DW-1:0] A_m [0:N-1][0:MAXK-1];
  logic [DW-1:0] B_m [0:MAXK-1][0:N-1];
  int n_pass  = 0;
  int n_total = 0;
  int job_no  = 0;

  // Operand buffer: one-cycle read latency, garbage when not being read.
  always @(posedge clk) begin
    logic [VW-1:0] va, vb;
    for (int i = 0; i < N; i++) begin
      if (bus.rd_en && (int'(bus.rd_addr) < MAXK)) begin
        va[i*DW +: DW] = A_m[i][bus.rd_addr];
        vb[i*DW +: DW] = B_m[bus.rd_addr][i];
      end else begin
        va[i*DW +: DW] = $urandom;
        vb[i*DW +: DW] = $urandom;
      end
    end
    bus.a_rd_data <= va;
    bus.b_rd_data <= vb;
  end

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic fill(input int pat, input int k);
    for (int t = 0; t < MAXK; t++) begin
      for (int i = 0; i < N; i++) begin
        case (pat)
          PAT_ID:   begin A_m[i][t] = (i == t) ? 1 : 0; B_m[t][i] = (i == t) ? 1 : 0; end
          PAT_SKEW: begin A_m[i][t] = DW'(i + 1);       B_m[t][i] = DW'(i + 4);       end
          PAT_ONES: begin A_m[i][t] = 1;                B_m[t][i] = 1;                end
          default:  begin A_m[i][t] = $urandom;         B_m[t][i] = $urandom;         end
        endcase
      end
    end
    if (k > MAXK) $display("note: k larger than buffer model");
  endtask

  // One job: start, then per-cycle comparison against the timing rules.
  task automatic run_job(input int k, input int exp_len, input int ev, input int ev_c, input bit tail);
    logic [DW-1:0] ah [0:63][0:N-1];
    logic [DW-1:0] bh [0:63][0:N-1];
    logic [DW-1:0] cm [0:N-1][0:N-1];
    logic [DW-1:0] pm;
    logic [VW-1:0] ea, eb;
    logic [4:0]    ectl;
    int kill, t;
    bit alive;
    kill = 1000;
    for (int c = 0; c < 64; c++)
      for (int i = 0; i < N; i++) begin ah[c][i] = '0; bh[c][i] = '0; end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = '0;
    job_no++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.k_len = KW'($urandom);
    for (int c = 1; c <= exp_len + int'(tail); c++) begin
      @(negedge clk);
      if (ev == EV_BUSY && c == ev_c)     begin bus.start = 1'b1; bus.k_len = KW'(9); end
      if (ev == EV_BUSY && c == ev_c + 1) bus.start = 1'b0;
      if (ev == EV_RST && c == ev_c)      begin rst_n = 1'b0; kill = c; end
      if (ev == EV_RST && c == ev_c + 2)  rst_n = 1'b1;
`ifdef SYSTOLIC_SEQ_ABORT_EN
      if (ev == EV_ABORT && c == ev_c)     begin bus.abort = 1'b1; kill = c + 1; end
      if (ev == EV_ABORT && c == ev_c + 1) bus.abort = 1'b0;
`endif
      #1;
      alive = (c < kill);
      ectl = '0;
      if (alive)
        ectl = {c <= exp_len, c == exp_len, (c >= 2) && (c <= k + 1), c == 1,
                (c >= 2) && (c <= exp_len - 1)};
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        t = c - 3 - i;
        if (alive && t >= 0 && t < k) begin
          ea[i*DW +: DW] = A_m[i][t];
          eb[i*DW +: DW] = B_m[t][i];
        end
      end
      check($sformatf("job%0d c%0d ctl{busy,done,rd_en,clr,en}", job_no, c),
            VW'({bus.busy, bus.done, bus.rd_en, bus.mac_clr, bus.mac_en}), VW'(ectl));
      check($sformatf("job%0d c%0d a_feed", job_no, c), bus.a_feed, ea);
      check($sformatf("job%0d c%0d b_feed", job_no, c), bus.b_feed, eb);
      if (alive && c >= 2 && c <= k + 1)
        check($sformatf("job%0d c%0d rd_addr", job_no, c), VW'(bus.rd_addr), VW'(c - 2));
      else if (!alive && ev == EV_RST)
        check($sformatf("job%0d c%0d rd_addr_rst", job_no, c), VW'(bus.rd_addr), '0);
      // Array model: PE(i,j) sees row i delayed j and column j delayed i.
      for (int i = 0; i < N; i++) begin
        ah[c][i] = lane(bus.a_feed, i);
        bh[c][i] = lane(bus.b_feed, i);
      end
      if (bus.mac_clr) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) cm[i][j] = '0;
      end else if (bus.mac_en) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (c - j >= 1 && c - i >= 1) cm[i][j] += ah[c-j][i] * bh[c-i][j];
      end
    end
    if (kill == 1000) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pm = '0;
          for (int tt = 0; tt < k; tt++) pm += A_m[i][tt] * B_m[tt][j];
          check($sformatf("job%0d C[%0d][%0d]", job_no, i, j), VW'(cm[i][j]), VW'(pm));
        end
    end
    $display("job %0d: K=%0d event=%0d at c%0d, expected length %0d, checks so far %0d/%0d",
             job_no, k, ev, ev_c, exp_len, n_pass, n_total);
  endtask

  initial begin
    vec_t vecs [6];
    int   k;
    vecs[0] = '{k: 4,  pat: PAT_ID,   exp_len: 12};
    vecs[1] = '{k: 1,  pat: PAT_SKEW, exp_len: 9};
    vecs[2] = '{k: 7,  pat: PAT_RAND, exp_len: 15};
    vecs[3] = '{k: 2,  pat: PAT_ONES, exp_len: 10};
    vecs[4] = '{k: 16, pat: PAT_RAND, exp_len: 24};
    vecs[5] = '{k: 1,  pat: PAT_RAND, exp_len: 9};

    // Reset held with start asserted: everything stays zero.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.k_len = KW'(5);
`ifdef SYSTOLIC_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    fill(PAT_ID, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("reset c%0d ctl", c),
            VW'({bus.busy, bus.done, bus.rd_en, bus.mac_clr, bus.mac_en}), '0);
      check($sformatf("reset c%0d rd_addr", c), VW'(bus.rd_addr), '0);
      check($sformatf("reset c%0d a_feed", c), bus.a_feed, '0);
      check($sformatf("reset c%0d b_feed", c), bus.b_feed, '0);
    end
    $display("reset hold: 4 cycles with start=1");
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // Zero-length command is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("k0 c%0d ctl", c),
            VW'({bus.busy, bus.done, bus.rd_en, bus.mac_clr, bus.mac_en}), '0);
    end
    $display("zero-length start: ignored check done");

    // Table of jobs.
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat, vecs[v].k);
      run_job(vecs[v].k, vecs[v].exp_len, EV_NONE, 0, 1'b1);
    end

    // Start while busy, then a back-to-back start right after done.
    fill(PAT_ID, 4);
    run_job(4, 12, EV_BUSY, 4, 1'b0);
    fill(PAT_RAND, 3);
    run_job(3, 11, EV_NONE, 0, 1'b1);

    // Reset in the middle of DRAIN, then a clean job.
    fill(PAT_RAND, 4);
    run_job(4, 12, EV_RST, 8, 1'b1);
    fill(PAT_RAND, 2);
    run_job(2, 10, EV_NONE, 0, 1'b1);

`ifdef SYSTOLIC_SEQ_ABORT_EN
    // Abort in FEED, then a short job completes normally.
    fill(PAT_RAND, 8);
    run_job(8, 16, EV_ABORT, 3, 1'b1);
    fill(PAT_RAND, 2);
    run_job(2, 10, EV_NONE, 0, 1'b1);
`endif

    // Randomized jobs with random idle gaps.
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(1, MAXK);
      fill(PAT_RAND, k);
      run_job(k, k + 2 * N + 2, EV_NONE, 0, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencing controller for the N×N systolic MAC array. On a start command it performs four steps:
- clears the array accumulators;
- fetches K operand slices from the operand buffer;
- applies the diagonal input skew (row i / column j delayed by i / j cycles);
- holds the array enabled until the last partial products have propagated, then pulses done.

It sits between the operand buffer and the array's per-row A and per-column B inputs.

## Interface
- DATA_WIDTH, 32, operand element width
- N, 3, array dimension (N×N MACs)
- K_WIDTH, 8, width of the inner-dimension length k_len

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- k_len  in  K_WIDTH  inner dimension K; sampled with start
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse at end of job
- rd_en  out  1  operand buffer read strobe
- rd_addr  out  K_WIDTH  slice index t
- a_rd_data  in  DATA_WIDTH*N  A column slice A[0..N-1][t]; valid one cycle after rd_en
- b_rd_data  in  DATA_WIDTH*N  B row slice B[t][0..N-1]; valid one cycle after rd_en
- a_feed  out  DATA_WIDTH*N  skewed A to array row i (element i at bits [DW*(i+1)-1 : DW*i])
- b_feed  out  DATA_WIDTH*N  skewed B to array column j
- mac_clr  out  1  synchronous accumulator clear to array
- mac_en  out  1  accumulate enable to array

## Operation
States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.

- **IDLE**
  - start=1 and k_len≠0: latch k_len, go to CLEAR.
  - start with k_len=0: ignored; no busy, no done.
- **CLEAR** (1 cycle): mac_clr=1, mac_en=0.
- **FEED** (K cycles)
  - rd_en=1, rd_addr counts 0..K-1, then go to DRAIN.
- **DRAIN** (2N cycles): rd_en=0; lets the read latency (1), skew (up to 2N-2) and MAC (1) complete.
- **DONE** (1 cycle): done=1, busy=1; return to IDLE.

Skew and enables:
- Skew chain per lane: a valid bit plus data.
  - Lane i receives a_rd_data element i delayed by i additional cycles (i registers).
  - Lane 0 is combinational from the returned data.
  - b lanes are identical.
- Any lane whose valid bit is 0 drives all-zero data, so array accumulators add 0.
- mac_en=1 in FEED and DRAIN, 0 otherwise.

Boundary conditions:
- start while busy: ignored.
- rd_addr is not wrapped; K ≤ 2^K_WIDTH−1.
- Reset asserted mid-job: immediately returns to IDLE; counters, skew registers and outputs are cleared; no done.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, mac_clr=0, mac_en=0, a_feed=0, b_feed=0.
- start accepted on edge E:
  - CLEAR in cycle E+1.
  - First rd_en in E+2.
  - Last rd_en in E+K+1.
  - done in cycle E+K+2N+2.
- Job length, start to done pulse inclusive: K+2N+2 cycles.
- Element (i,t) of A reaches a_feed lane i in cycle E+3+t+i; B lane j likewise with j.
- Earliest next start: cycle after done. Back-to-back throughput is K+2N+3 cycles per job.

## Configuration
- SYSTOLIC_SEQ_ABORT_EN
  - Defined: adds input port abort (1 bit). abort=1 in CLEAR, FEED or DRAIN goes to IDLE next cycle.
    - busy drops, no done.
    - Skew registers are zeroed.
    - abort in IDLE or DONE is ignored.
  - Undefined: port absent; the job always runs to completion.

## Test plan
- **Reset**: hold rst=0 with start=1 → every output 0 throughout; release → IDLE; start with k_len=0 → no busy, no done.
- **Single job**, N=3, K=4, identity A and B fed from a buffer model:
  - done exactly 4+6+2=12 cycles after start, inclusive.
  - rd_addr sequence 0,1,2,3.
  - Reference array C equals identity.
- **Skew check**, K=1, A slice {1,2,3}, B slice {4,5,6}:
  - a_feed lanes carry 1, 2, 3 in cycles E+3, E+4, E+5; b_feed likewise with 4, 5, 6.
  - All other cycles zero.
- **Start while busy**:
  - Pulse start with k_len=9 mid-FEED of a K=4 job → ignored; done at original time.
  - Immediate next start accepted after done.
- **Reset mid-DRAIN**: assert rst → outputs reset asynchronously; no done pulse; next job completes correctly.
- **SYSTOLIC_SEQ_ABORT_EN**: abort at FEED cycle 2 of K=8 → busy=0 next cycle, no done, feeds zero; a subsequent K=2 job completes in 10 cycles.
